// File: rtl/wb_timer_pkg.sv
// Shared definitions for the Wishbone machine timer: register map,
// CTRL/STATUS bit positions, reset values and a byte-lane merge helper.
package wb_timer_pkg;

    typedef enum logic [2:0] {
        REG_MTIME_LO    = 3'd0,
        REG_MTIME_HI    = 3'd1,
        REG_MTIMECMP_LO = 3'd2,
        REG_MTIMECMP_HI = 3'd3,
        REG_CTRL        = 3'd4,
        REG_STATUS      = 3'd5
    } reg_off_e;

    localparam int CTRL_EN_BIT       = 0;
    localparam int CTRL_IRQ_EN_BIT   = 1;
    localparam int CTRL_RELOAD_LSB   = 16;
    localparam int STATUS_MATCH_BIT  = 0;
    localparam int STATUS_PEND_BIT   = 1;

    localparam logic [63:0] MTIME_RST    = 64'h0;
    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [31:0] CTRL_RST     = 32'h0;

    // Replace only the bytes whose lane enable is set.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) begin
                res[8*b +: 8] = new_v[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_timer_prescaler.sv
// Down-counting prescaler: emits a one-cycle tick when it reaches zero
// while enabled, then reloads. Frozen while disabled; any CTRL write reloads.
module wb_timer_prescaler #(
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                      wb_clk,
    input  logic                      wb_rst_n,
    input  logic                      en,
    input  logic                      ctrl_wr,
    input  logic [PRESCALE_WIDTH-1:0] reload,
    output logic                      tick
);

    logic [PRESCALE_WIDTH-1:0] count_q;
    logic [PRESCALE_WIDTH-1:0] count_d;

    // Next count and tick; a CTRL write restarts the period from the new reload.
    always_comb begin
        tick    = en && (count_q == '0);
        count_d = count_q;
        if (ctrl_wr) begin
            count_d = reload;
        end else if (tick) begin
            count_d = reload;
        end else if (en) begin
            count_d = count_q - PRESCALE_WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/wb_timer.sv
// Wishbone classic machine timer: 64-bit MTIME/MTIMECMP, prescaled tick,
// coherent HI read via shadow, sticky pending flag and level interrupt.
module wb_timer
    import wb_timer_pkg::*;
#(
    parameter int WB_DATA_WIDTH  = 32,
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                     wb_clk,
    input  logic                     wb_rst_n,
    input  logic [WB_DATA_WIDTH-1:0] s_wb_adr,
    input  logic [WB_DATA_WIDTH-1:0] s_wb_dat,
    input  logic [3:0]               s_wb_sel,
    input  logic                     s_wb_we,
    input  logic                     s_wb_cyc,
    output logic [WB_DATA_WIDTH-1:0] s_wb_rdt,
    output logic                     s_wb_ack,
    output logic                     o_timer_irq
);

    localparam logic [31:0] CTRL_MASK =
        (((32'd1 << PRESCALE_WIDTH) - 32'd1) << CTRL_RELOAD_LSB) | 32'h3;

    logic        ack_q, ack_d;
    logic [31:0] rdt_q, rdt_d;
    logic        irq_q, irq_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] cmp_q, cmp_d;
    logic [31:0] shadow_q, shadow_d;
    logic [31:0] ctrl_q, ctrl_d;
    logic        pend_q, pend_d;

    logic [2:0]  offset;
    logic        access;
    logic        wr_any;
    logic        ctrl_wr;
    logic        match;
    logic        tick;
    logic [31:0] rd_data;
    logic        unused_adr;

    assign offset     = s_wb_adr[4:2];
    assign unused_adr = ^{s_wb_adr[WB_DATA_WIDTH-1:5], s_wb_adr[1:0]};
    // An access completes on the edge that raises ack; back-to-back cyc alternates.
    assign access     = s_wb_cyc && !ack_q;
    assign wr_any     = access && s_wb_we && (s_wb_sel != 4'b0000);
    assign ctrl_wr    = wr_any && (offset == REG_CTRL);
    assign match      = (mtime_q >= cmp_q);

    assign s_wb_ack    = ack_q;
    assign s_wb_rdt    = rdt_q;
    assign o_timer_irq = irq_q;

    wb_timer_prescaler #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_prescaler (
        .wb_clk   (wb_clk),
        .wb_rst_n (wb_rst_n),
        .en       (ctrl_q[CTRL_EN_BIT]),
        .ctrl_wr  (ctrl_wr),
        .reload   (ctrl_d[CTRL_RELOAD_LSB +: PRESCALE_WIDTH]),
        .tick     (tick)
    );

    // Read-data mux; HI returns the shadow captured by the last LO read.
    always_comb begin
        rd_data = 32'h0;
        case (offset)
            REG_MTIME_LO:    rd_data = mtime_q[31:0];
            REG_MTIME_HI:    rd_data = shadow_q;
            REG_MTIMECMP_LO: rd_data = cmp_q[31:0];
            REG_MTIMECMP_HI: rd_data = cmp_q[63:32];
            REG_CTRL:        rd_data = ctrl_q;
            REG_STATUS: begin
                rd_data[STATUS_MATCH_BIT] = match;
                rd_data[STATUS_PEND_BIT]  = pend_q;
            end
            default:         rd_data = 32'h0;
        endcase
    end

    // Next-state for bus response and registers; a bus write to MTIME beats a tick.
    always_comb begin
        ack_d    = access;
        rdt_d    = rdt_q;
        irq_d    = ctrl_q[CTRL_IRQ_EN_BIT] && match;
        mtime_d  = tick ? (mtime_q + 64'd1) : mtime_q;
        cmp_d    = cmp_q;
        shadow_d = shadow_q;
        ctrl_d   = ctrl_q;
        pend_d   = pend_q;

        if (access) begin
            rdt_d = rd_data;
            if (!s_wb_we && (offset == REG_MTIME_LO)) begin
                shadow_d = mtime_q[63:32];
            end
        end

        if (wr_any) begin
            case (offset)
                REG_MTIME_LO:
                    mtime_d = {mtime_q[63:32], byte_merge(mtime_q[31:0], s_wb_dat, s_wb_sel)};
                REG_MTIME_HI:
                    mtime_d = {byte_merge(mtime_q[63:32], s_wb_dat, s_wb_sel), mtime_q[31:0]};
                REG_MTIMECMP_LO:
                    cmp_d[31:0] = byte_merge(cmp_q[31:0], s_wb_dat, s_wb_sel);
                REG_MTIMECMP_HI:
                    cmp_d[63:32] = byte_merge(cmp_q[63:32], s_wb_dat, s_wb_sel);
                REG_CTRL:
                    ctrl_d = byte_merge(ctrl_q, s_wb_dat, s_wb_sel) & CTRL_MASK;
                REG_STATUS:
                    if (s_wb_sel[0] && s_wb_dat[STATUS_PEND_BIT]) begin
                        pend_d = 1'b0;
                    end
                default: ;
            endcase
        end

        // A match in the same cycle as the clear keeps PEND set.
        if (match) begin
            pend_d = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            ack_q    <= 1'b0;
            rdt_q    <= 32'h0;
            irq_q    <= 1'b0;
            mtime_q  <= MTIME_RST;
            cmp_q    <= MTIMECMP_RST;
            shadow_q <= 32'h0;
            ctrl_q   <= CTRL_RST;
            pend_q   <= 1'b0;
        end else begin
            ack_q    <= ack_d;
            rdt_q    <= rdt_d;
            irq_q    <= irq_d;
            mtime_q  <= mtime_d;
            cmp_q    <= cmp_d;
            shadow_q <= shadow_d;
            ctrl_q   <= ctrl_d;
            pend_q   <= pend_d;
        end
    end

endmodule

// File: tb/tb_wb_timer.sv
// Self-checking bench for wb_timer: a register-map level model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_wb_timer;

    logic        wb_clk = 1'b0;
    logic        wb_rst_n = 1'b0;
    logic [31:0] s_wb_adr = '0;
    logic [31:0] s_wb_dat = '0;
    logic [3:0]  s_wb_sel = '0;
    logic        s_wb_we = 1'b0;
    logic        s_wb_cyc = 1'b0;
    logic [31:0] s_wb_rdt;
    logic        s_wb_ack;
    logic        o_timer_irq;

    int n_cmp = 0;
    int n_err = 0;

    always #5 wb_clk = ~wb_clk;

    wb_timer #(
        .WB_DATA_WIDTH  (32),
        .PRESCALE_WIDTH (16)
    ) dut (
        .wb_clk      (wb_clk),
        .wb_rst_n    (wb_rst_n),
        .s_wb_adr    (s_wb_adr),
        .s_wb_dat    (s_wb_dat),
        .s_wb_sel    (s_wb_sel),
        .s_wb_we     (s_wb_we),
        .s_wb_cyc    (s_wb_cyc),
        .s_wb_rdt    (s_wb_rdt),
        .s_wb_ack    (s_wb_ack),
        .o_timer_irq (o_timer_irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = s[b] ? d[8*b +: 8] : o[8*b +: 8];
        end
        return r;
    endfunction

    // ---------------- behavioural model (register map level) ----------------
    logic [63:0] m_mtime, m_cmp;
    logic [31:0] m_shadow, m_ctrl, m_rdt;
    logic        m_pend, m_ack, m_irq;
    int          m_wait;   // cycles left before the next tick while enabled

    always @(posedge wb_clk or negedge wb_rst_n) begin : model
        logic        acc, wr, rd, mt, tk;
        logic [2:0]  off;
        logic [31:0] rv, nc;
        if (!wb_rst_n) begin
            m_mtime  <= 64'h0;
            m_cmp    <= 64'hFFFF_FFFF_FFFF_FFFF;
            m_shadow <= 32'h0;
            m_ctrl   <= 32'h0;
            m_rdt    <= 32'h0;
            m_pend   <= 1'b0;
            m_ack    <= 1'b0;
            m_irq    <= 1'b0;
            m_wait   <= 0;
        end else begin
            off = s_wb_adr[4:2];
            acc = s_wb_cyc && !m_ack;
            wr  = acc && s_wb_we && (s_wb_sel != 4'b0);
            rd  = acc && !s_wb_we;
            mt  = (m_mtime >= m_cmp);
            tk  = m_ctrl[0] && (m_wait == 0);
            case (off)
                3'd0:    rv = m_mtime[31:0];
                3'd1:    rv = m_shadow;
                3'd2:    rv = m_cmp[31:0];
                3'd3:    rv = m_cmp[63:32];
                3'd4:    rv = m_ctrl;
                3'd5:    rv = {30'b0, m_pend, mt};
                default: rv = 32'h0;
            endcase
            m_ack <= acc;
            if (acc) m_rdt <= rv;
            m_irq <= m_ctrl[1] && mt;

            if (wr && off == 3'd0)      m_mtime <= {m_mtime[63:32], lanes(m_mtime[31:0], s_wb_dat, s_wb_sel)};
            else if (wr && off == 3'd1) m_mtime <= {lanes(m_mtime[63:32], s_wb_dat, s_wb_sel), m_mtime[31:0]};
            else if (tk)                m_mtime <= m_mtime + 64'd1;

            if (rd && off == 3'd0) m_shadow <= m_mtime[63:32];
            if (wr && off == 3'd2) m_cmp[31:0]  <= lanes(m_cmp[31:0], s_wb_dat, s_wb_sel);
            if (wr && off == 3'd3) m_cmp[63:32] <= lanes(m_cmp[63:32], s_wb_dat, s_wb_sel);

            if (wr && off == 3'd4) begin
                nc = lanes(m_ctrl, s_wb_dat, s_wb_sel) & 32'hFFFF_0003;
                m_ctrl <= nc;
                m_wait <= int'(nc[31:16]);
            end else if (tk) begin
                m_wait <= int'(m_ctrl[31:16]);
            end else if (m_ctrl[0]) begin
                m_wait <= m_wait - 1;
            end

            if (mt) m_pend <= 1'b1;
            else if (wr && off == 3'd5 && s_wb_sel[0] && s_wb_dat[1]) m_pend <= 1'b0;
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge wb_clk) begin
        if (wb_rst_n) begin
            check("cyc_ack", {31'b0, s_wb_ack}, {31'b0, m_ack});
            check("cyc_irq", {31'b0, o_timer_irq}, {31'b0, m_irq});
            check("cyc_rdt", s_wb_rdt, m_rdt);
        end
    end

    // ---------------- bus tasks ----------------
    task automatic bus_write(input logic [2:0] off, input logic [31:0] d, input logic [3:0] sel);
        @(negedge wb_clk);
        s_wb_adr = {27'b0, off, 2'b00};
        s_wb_dat = d;
        s_wb_sel = sel;
        s_wb_we  = 1'b1;
        s_wb_cyc = 1'b1;
        @(negedge wb_clk);
        check("wr_ack", {31'b0, s_wb_ack}, 32'd1);
        s_wb_cyc = 1'b0;
        s_wb_we  = 1'b0;
        $display("WR off=%0d data=0x%08h sel=%b ack=%0b", off, d, sel, s_wb_ack);
    endtask

    task automatic bus_read(input logic [2:0] off, output logic [31:0] d);
        @(negedge wb_clk);
        s_wb_adr = {27'b0, off, 2'b00};
        s_wb_we  = 1'b0;
        s_wb_sel = 4'hF;
        s_wb_cyc = 1'b1;
        @(negedge wb_clk);
        check("rd_ack", {31'b0, s_wb_ack}, 32'd1);
        d = s_wb_rdt;
        s_wb_cyc = 1'b0;
        $display("RD off=%0d data=0x%08h ack=%0b", off, d, s_wb_ack);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- directed scenarios ----------------
    initial begin : stim
        logic [31:0] d;
        int          k;
        repeat (3) @(negedge wb_clk);
        wb_rst_n = 1'b1;

        // Reset state: CTRL reads 0, no interrupt.
        check("rst_irq", {31'b0, o_timer_irq}, 32'd0);
        bus_read(3'd4, d);
        check("rst_ctrl", d, 32'h0);
        bus_read(3'd3, d);
        check("rst_cmp_hi", d, 32'hFFFF_FFFF);

        // EN with RELOAD=3: one tick every 4 cycles.
        bus_write(3'd4, 32'h0003_0001, 4'hF);
        repeat (40) @(negedge wb_clk);
        bus_read(3'd0, d);
        n_cmp++;
        if (d < 32'd9 || d > 32'd11) begin
            n_err++;
            $display("FAIL presc_rate: got %0d, expected 10 +/-1", d);
        end
        bus_read(3'd4, d);
        check("ctrl_rb", d, 32'h0003_0001);

        // All-ones MTIME wraps to zero on the next tick.
        bus_write(3'd4, 32'h0, 4'hF);
        bus_write(3'd0, 32'hFFFF_FFFF, 4'hF);
        bus_write(3'd1, 32'hFFFF_FFFF, 4'hF);
        bus_write(3'd4, 32'h0000_0001, 4'hF);
        bus_read(3'd0, d);
        check("wrap_lo", d, 32'h0);
        bus_read(3'd1, d);
        check("wrap_hi", d, 32'h0);

        // LO wraps between LO and HI reads: HI returns the pre-wrap shadow.
        bus_write(3'd4, 32'h0, 4'hF);
        bus_write(3'd0, 32'hFFFF_FFFE, 4'hF);
        bus_write(3'd1, 32'h0000_0007, 4'hF);
        bus_write(3'd4, 32'h0000_0001, 4'hF);
        bus_read(3'd0, d);
        check("shadow_lo", d, 32'hFFFF_FFFF);
        bus_read(3'd1, d);
        check("shadow_hi", d, 32'h0000_0007);

        // Compare at 5 with IRQ_EN: irq rises one cycle after MTIME reaches 5.
        bus_write(3'd4, 32'h0, 4'hF);
        bus_write(3'd0, 32'h0, 4'hF);
        bus_write(3'd1, 32'h0, 4'hF);
        bus_write(3'd3, 32'h0, 4'hF);
        bus_write(3'd2, 32'h5, 4'hF);
        bus_write(3'd5, 32'h2, 4'h1);
        bus_read(3'd5, d);
        check("status_clr", d, 32'h0);
        bus_write(3'd4, 32'h0000_0003, 4'hF);
        k = 0;
        while (!o_timer_irq && k < 20) begin
            @(negedge wb_clk);
            k++;
        end
        check("irq_latency", k, 32'd6);
        bus_write(3'd5, 32'h2, 4'h1);
        bus_read(3'd5, d);
        check("pend_sticky", d & 32'h3, 32'h3);
        bus_write(3'd3, 32'hFFFF_FFFF, 4'hF);
        check("irq_hold", {31'b0, o_timer_irq}, 32'd1);
        @(negedge wb_clk);
        check("irq_drop", {31'b0, o_timer_irq}, 32'd0);
        bus_write(3'd4, 32'h0, 4'hF);

        // cyc held for 6 cycles gives 3 acks.
        @(negedge wb_clk);
        s_wb_adr = 32'h10;
        s_wb_we  = 1'b0;
        s_wb_cyc = 1'b1;
        k = 0;
        repeat (6) begin
            @(negedge wb_clk);
            if (s_wb_ack) k++;
        end
        s_wb_cyc = 1'b0;
        $display("BURST cycles=6 acks=%0d", k);
        check("burst_acks", k, 32'd3);

        // Byte lane write, zero-lane write, unmapped offsets.
        bus_write(3'd2, 32'hAABB_CCDD, 4'b0010);
        bus_read(3'd2, d);
        check("byte_lane", d, 32'h0000_CC05);
        bus_write(3'd2, 32'h1234_5678, 4'b0000);
        bus_read(3'd2, d);
        check("sel_zero", d, 32'h0000_CC05);
        bus_write(3'd7, 32'hFFFF_FFFF, 4'hF);
        bus_read(3'd7, d);
        check("unmapped7", d, 32'h0);
        bus_read(3'd6, d);
        check("unmapped6", d, 32'h0);

        // Reset asserted mid-access leaves no ack pending.
        @(negedge wb_clk);
        s_wb_adr = 32'h0;
        s_wb_cyc = 1'b1;
        #2 wb_rst_n = 1'b0;
        @(negedge wb_clk);
        check("rst_mid_ack", {31'b0, s_wb_ack}, 32'd0);
        s_wb_cyc = 1'b0;
        @(negedge wb_clk);
        wb_rst_n = 1'b1;
        @(negedge wb_clk);
        check("rst_rel_ack", {31'b0, s_wb_ack}, 32'd0);
        bus_read(3'd3, d);
        check("rst_cmp_again", d, 32'hFFFF_FFFF);

        repeat (2) @(negedge wb_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
